// File: rtl/iir_pkg.sv
// iir_pkg: shared widths, checker state encoding and the signed abs-difference helper.
package iir_pkg;
  localparam int DW_DEF = 32;
  localparam int CW_DEF = 20;
  localparam int FIFO_AW_DEF = 3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_t;
  // Operands arrive sign-extended to 64 bits; one extra bit keeps the difference exact.
  function automatic logic [64:0] abs_diff(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] d;
    d = {a[63], a} - {b[63], b};
    return d[64] ? -d : d;
  endfunction
endpackage

// File: rtl/iir_sample_fifo.sv
// iir_sample_fifo: synchronous expected-sample FIFO with flush; full/empty from the extra pointer MSB.
module iir_sample_fifo #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] r_mem [2**AW];
  logic [AW:0]   r_wp, r_rp;
  logic          w_wr, w_rd;
  assign empty   = r_wp == r_rp;
  assign full    = (r_wp[AW] != r_rp[AW]) & (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign rd_data = r_mem[r_rp[AW-1:0]];
  assign w_wr    = push & ~full & ~flush;
  assign w_rd    = pop & ~empty & ~flush;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/iir_stream_checker.sv
// iir_stream_checker: compares filter output against buffered golden samples and keeps per-run error stats.
module iir_stream_checker
  import iir_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int CW      = CW_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF,
  parameter int TOL     = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] num_samples,
  input  logic          exp_valid,
  input  logic [DW-1:0] exp_data,
  output logic          exp_ready,
  input  logic          dut_valid,
  input  logic [DW-1:0] dut_data,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] err_count,
  output logic [DW:0]   max_abs_diff,
  output logic [CW-1:0] last_err_idx,
  output logic          underflow
);
  chk_state_t    r_state, w_next;
  logic [CW-1:0] r_idx, r_num, r_err, r_last;
  logic [DW:0]   r_max, w_abs;
  logic          r_uf;
  logic          w_full, w_empty, w_start, w_fire, w_pop, w_uf, w_err, w_last;
  logic [DW-1:0] w_head;

  assign w_start   = start & (r_state != RUN);
  assign w_fire    = (r_state == RUN) & dut_valid;
  assign w_pop     = w_fire & ~w_empty;
  assign w_uf      = w_fire & w_empty;
  assign w_abs     = (DW+1)'(abs_diff(64'($signed(dut_data)), 64'($signed(w_head))));
  assign w_err     = w_uf | (w_pop & (w_abs > (DW+1)'(TOL)));
  assign w_last    = w_fire & (r_idx == r_num - 1'b1);
  assign exp_ready = (r_state == RUN) & ~w_full;

  assign busy         = r_state == RUN;
  assign done         = r_state == DONE;
  assign err_count    = r_err;
  assign max_abs_diff = r_max;
  assign last_err_idx = r_last;
  assign underflow    = r_uf;

  iir_sample_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (w_start),
    .push    (exp_valid & exp_ready),
    .pop     (w_pop),
    .wr_data (exp_data),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_comb begin
    w_next = r_state;
    w_next = w_start ? ((num_samples == '0) ? DONE : RUN) : w_last ? DONE : r_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_num   <= '0;
      r_idx   <= '0;
      r_err   <= '0;
      r_max   <= '0;
      r_last  <= '0;
      r_uf    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_num  <= num_samples;
        r_idx  <= '0;
        r_err  <= '0;
        r_max  <= '0;
        r_last <= '0;
        r_uf   <= 1'b0;
      end else if (w_fire) begin
        r_idx <= r_idx + 1'b1;
        if (w_err) begin
          r_err  <= (&r_err) ? r_err : r_err + 1'b1;
          r_last <= r_idx;
        end
        if (w_pop && (w_abs > r_max)) r_max <= w_abs;
        if (w_uf) r_uf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_iir_stream_checker.sv
// tb_iir_stream_checker: directed scenario tasks with hand-computed expectations for iir_stream_checker.
module tb_iir_stream_checker;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [19:0] num_samples = '0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data = '0;
  logic        exp_ready;
  logic        dut_valid = 1'b0;
  logic [31:0] dut_data = '0;
  logic        busy, done, underflow;
  logic [19:0] err_count, last_err_idx;
  logic [32:0] max_abs_diff;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iir_stream_checker dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_samples  (num_samples),
    .exp_valid    (exp_valid),
    .exp_data     (exp_data),
    .exp_ready    (exp_ready),
    .dut_valid    (dut_valid),
    .dut_data     (dut_data),
    .busy         (busy),
    .done         (done),
    .err_count    (err_count),
    .max_abs_diff (max_abs_diff),
    .last_err_idx (last_err_idx),
    .underflow    (underflow)
  );

  task automatic do_start(input logic [19:0] n);
    start = 1'b1;
    num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] v);
    int n;
    n = 0;
    exp_valid = 1'b1;
    exp_data = v;
    while (!exp_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      checks++;
      errs++;
      $display("FAIL push_timeout exp_ready got %b want 1", exp_ready);
    end
    @(negedge clk);
    exp_valid = 1'b0;
  endtask

  task automatic send_dut(input logic [31:0] v);
    dut_valid = 1'b1;
    dut_data = v;
    @(negedge clk);
    dut_valid = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    checks++;
    if ({exp_ready, busy, done, underflow} !== 4'b0000) begin
      errs++;
      $display("FAIL %s_flags got %b want 0000", tag, {exp_ready, busy, done, underflow});
    end
    checks++;
    if ({err_count, last_err_idx, max_abs_diff} !== 73'd0) begin
      errs++;
      $display("FAIL %s_stats got err=%0d idx=%0d max=%h want 0", tag, err_count, last_err_idx, max_abs_diff);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_zero("post_reset");
  endtask

  task automatic test_match();
    logic [31:0] v [4] = '{32'd10, -32'sd5, 32'd0, 32'd7};
    do_start(20'd4);
    checks++;
    if (busy !== 1'b1 || exp_ready !== 1'b1) begin
      errs++;
      $display("FAIL match_busy got busy=%b rdy=%b want 1 1", busy, exp_ready);
    end
    for (int i = 0; i < 4; i++) push_exp(v[i]);
    for (int i = 0; i < 4; i++) send_dut(v[i]);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL match_done got done=%b busy=%b want 1 0", done, busy);
    end
    checks++;
    if (err_count !== 20'd0 || max_abs_diff !== 33'd0) begin
      errs++;
      $display("FAIL match_stats got err=%0d max=%h want 0 0", err_count, max_abs_diff);
    end
  endtask

  task automatic test_mismatch();
    do_start(20'd3);
    push_exp(32'd100);
    push_exp(32'd200);
    push_exp(32'd300);
    send_dut(32'd100);
    send_dut(32'd203);
    checks++;
    if (err_count !== 20'd1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL mism_mid got err=%0d busy=%b want 1 1", err_count, busy);
    end
    send_dut(32'd300);
    checks++;
    if (err_count !== 20'd1 || last_err_idx !== 20'd1 || max_abs_diff !== 33'd3) begin
      errs++;
      $display("FAIL mism_stats got err=%0d idx=%0d max=%h want 1 1 3", err_count, last_err_idx, max_abs_diff);
    end
    checks++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL mism_done got %b want 1", done);
    end
  endtask

  task automatic test_extreme();
    do_start(20'd1);
    checks++;
    if (err_count !== 20'd0 || max_abs_diff !== 33'd0 || done !== 1'b0) begin
      errs++;
      $display("FAIL ext_clear got err=%0d max=%h done=%b want 0 0 0", err_count, max_abs_diff, done);
    end
    push_exp(32'h7FFF_FFFF);
    send_dut(32'h8000_0000);
    checks++;
    if (max_abs_diff !== 33'h0_FFFF_FFFF) begin
      errs++;
      $display("FAIL ext_max got %h want 0ffffffff", max_abs_diff);
    end
    checks++;
    if (err_count !== 20'd1 || last_err_idx !== 20'd0 || done !== 1'b1) begin
      errs++;
      $display("FAIL ext_err got err=%0d idx=%0d done=%b want 1 0 1", err_count, last_err_idx, done);
    end
  endtask

  task automatic test_fifo_full();
    do_start(20'd9);
    for (int i = 1; i <= 8; i++) push_exp(32'(i));
    checks++;
    if (exp_ready !== 1'b0) begin
      errs++;
      $display("FAIL full_ready got %b want 0", exp_ready);
    end
    exp_valid = 1'b1;
    exp_data = 32'd9;
    @(negedge clk);
    checks++;
    if (exp_ready !== 1'b0) begin
      errs++;
      $display("FAIL full_hold got %b want 0", exp_ready);
    end
    send_dut(32'd1);
    checks++;
    if (exp_ready !== 1'b1) begin
      errs++;
      $display("FAIL full_reopen got %b want 1", exp_ready);
    end
    @(negedge clk);
    exp_valid = 1'b0;
    for (int i = 2; i <= 9; i++) send_dut(32'(i));
    checks++;
    if (done !== 1'b1 || err_count !== 20'd0 || underflow !== 1'b0 || max_abs_diff !== 33'd0) begin
      errs++;
      $display("FAIL full_result got done=%b err=%0d uf=%b max=%h want 1 0 0 0", done, err_count, underflow, max_abs_diff);
    end
  endtask

  task automatic test_underflow();
    do_start(20'd2);
    send_dut(32'd5);
    checks++;
    if (underflow !== 1'b1 || err_count !== 20'd1 || last_err_idx !== 20'd0) begin
      errs++;
      $display("FAIL uf_flag got uf=%b err=%0d idx=%0d want 1 1 0", underflow, err_count, last_err_idx);
    end
    do_start(20'd0);
    checks++;
    if (busy !== 1'b1 || err_count !== 20'd1 || underflow !== 1'b1) begin
      errs++;
      $display("FAIL uf_start_ignored got busy=%b err=%0d uf=%b want 1 1 1", busy, err_count, underflow);
    end
    push_exp(32'd5);
    send_dut(32'd5);
    checks++;
    if (done !== 1'b1 || err_count !== 20'd1 || underflow !== 1'b1 || max_abs_diff !== 33'd0) begin
      errs++;
      $display("FAIL uf_done got done=%b err=%0d uf=%b max=%h want 1 1 1 0", done, err_count, underflow, max_abs_diff);
    end
    do_start(20'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err_count !== 20'd0 || underflow !== 1'b0) begin
      errs++;
      $display("FAIL zero_run got done=%b busy=%b err=%0d uf=%b want 1 0 0 0", done, busy, err_count, underflow);
    end
  endtask

  task automatic test_reset_mid_run();
    do_start(20'd4);
    push_exp(32'd1);
    push_exp(32'd2);
    send_dut(32'd1);
    send_dut(32'd5);
    checks++;
    if (err_count !== 20'd1 || max_abs_diff !== 33'd3 || busy !== 1'b1) begin
      errs++;
      $display("FAIL mid_pre got err=%0d max=%h busy=%b want 1 3 1", err_count, max_abs_diff, busy);
    end
    reset = 1'b0;
    #1;
    check_idle_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_zero("mid_release");
    do_start(20'd2);
    push_exp(32'd3);
    push_exp(32'd4);
    send_dut(32'd3);
    send_dut(32'd4);
    checks++;
    if (done !== 1'b1 || err_count !== 20'd0 || underflow !== 1'b0 || max_abs_diff !== 33'd0) begin
      errs++;
      $display("FAIL mid_rerun got done=%b err=%0d uf=%b max=%h want 1 0 0 0", done, err_count, underflow, max_abs_diff);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_extreme();
    test_fifo_full();
    test_underflow();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
